alu_srcb_stage: RTL and testbench
=================================

// Module: alu_srcb_stage
// PURPOSE
//  Registered, parametrised ALU operand-B source stage for the multicycle datapath.
//  Selects B register, constant, or one of several extended/shifted immediate forms.
//  Delivers the result through a valid/ready handshake with a 2-entry skid buffer,
//  so the control FSM can stall the ALU without losing an issued operand.
// PARAMETERS
//  DATA_W    32  operand / output width
//  IMM_W     16  immediate field width (IMM_W < DATA_W - 2)
//  CONST_VAL 4   value driven for SEL_CONST (PC increment)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-low reset
//  flush      in   1       sync clear of buffered entries (exception/branch redirect)
//  in_valid   in   1       request: sel/b_in/imm_in valid this cycle
//  in_ready   out  1       stage can accept a request
//  sel        in   3       source select, encodings in alu_srcb_pkg
//  b_in       in   DATA_W  register-B operand
//  imm_in     in   IMM_W   instruction immediate field
//  out_valid  out  1       out_data/out_err valid
//  out_ready  in   1       ALU consumes head entry
//  out_data   out  DATA_W  selected operand
//  out_err    out  1       head entry was issued with a reserved sel code
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-low.
//  Select (sel): 000 b_in; 001 CONST_VAL; 010 sign-ext imm; 011 sign-ext imm << 2;
//   100 zero-ext imm; 101 imm << (DATA_W-IMM_W) (LUI form, low bits 0);
//   110/111 reserved -> data 0, err 1. Shifts drop upper bits, no saturation.
//  Transfer in: in_valid & in_ready; transfer out: out_valid & out_ready.
//  Latency: an accepted request appears on out_* the next cycle when the buffer was empty.
//  Buffer: head register + skid register; FSM states EMPTY, ONE, TWO.
//   EMPTY: in xfer -> ONE (head <= new).
//   ONE: in xfer & out xfer -> ONE (head <= new); in only -> TWO (skid <= new);
//        out only -> EMPTY.
//   TWO: out xfer -> ONE (head <= skid); no input accepted.
//  in_ready = (state != TWO) & ~flush; out_valid = (state != EMPTY).
//  out_data/out_err always reflect head; stable while out_valid & ~out_ready.
//  flush: next state EMPTY, both entries discarded; a same-cycle in_valid is dropped
//   (in_ready low); a same-cycle out xfer still completes.
//  Reset (reset == 0 at edge): state EMPTY, out_valid 0, out_data 0, out_err 0,
//   in_ready 0 during the reset cycle and 1 afterwards. Reset mid-operation
//   discards all entries; reset has priority over flush.
//  No combinational path from out_ready to out_data; in_ready depends only on state/flush.
// STRUCTURE
//  alu_srcb_pkg: SEL_* localparams (3-bit encodings above), state encodings.
//  Sub-module alu_srcb_sel: pure combinational select/extend/shift
//   (DATA_W, IMM_W, CONST_VAL) -> {err, data}; the stage instantiates one.
//  Top: FSM, head/skid registers (DATA_W+1 each), handshake logic.
// TESTING
//  1 sel=011, imm=16'hFFFE, out_ready=1 -> next cycle out_data=32'hFFFF_FFF8, err=0.
//  2 sel=101, imm=16'h1234 -> 32'h1234_0000; sel=100, imm=16'h8000 -> 32'h0000_8000.
//  3 out_ready=0, issue A=B_in 5, B=B_in 7 -> state TWO, in_ready=0, out_data=5;
//    raise out_ready -> 5 then 7 on consecutive cycles, no loss or duplication.
//  4 sel=110 -> out_data=0, out_err=1; next sel=001 -> out_data=4, out_err=0.
//  5 state TWO, assert flush with in_valid=1 -> next cycle out_valid=0, input dropped.
//  6 reset=0 while state ONE -> out_valid=0, out_data=0; first accept after reset
//    with sel=000, b_in=32'hDEAD_BEEF -> 1-cycle latency, out_data=32'hDEAD_BEEF.

Source files
------------

// File: rtl/alu_srcb_pkg.sv
// Shared encodings for the ALU operand-B source stage.
// Select codes and buffer FSM states.
package alu_srcb_pkg;

  localparam logic [2:0] SEL_B     = 3'b000;
  localparam logic [2:0] SEL_CONST = 3'b001;
  localparam logic [2:0] SEL_SEXT  = 3'b010;
  localparam logic [2:0] SEL_SEXT4 = 3'b011;
  localparam logic [2:0] SEL_ZEXT  = 3'b100;
  localparam logic [2:0] SEL_LUI   = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_srcb_if.sv
// Request/response handshake bundle for the operand-B stage.
// master = requester/consumer side, slave = the stage.
interface alu_srcb_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) ();

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        sel;
  logic [DATA_W-1:0] b_in;
  logic [IMM_W-1:0]  imm_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  modport master (
    output in_valid, sel, b_in, imm_in, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, sel, b_in, imm_in, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/alu_srcb_sel.sv
// Combinational operand-B select, extend and shift.
// Reserved select codes yield zero data with err set.
module alu_srcb_sel
  import alu_srcb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int IMM_W     = 16,
  parameter int CONST_VAL = 4
) (
  input  logic [2:0]        sel,
  input  logic [DATA_W-1:0] b_in,
  input  logic [IMM_W-1:0]  imm_in,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  localparam int PAD = DATA_W - IMM_W;

  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] zext;
  logic [DATA_W-1:0] lui;
  logic [DATA_W-1:0] sext4;

  assign sext  = {{PAD{imm_in[IMM_W-1]}}, imm_in};
  assign zext  = {{PAD{1'b0}}, imm_in};
  assign lui   = {imm_in, {PAD{1'b0}}};
  assign sext4 = {sext[DATA_W-3:0], 2'b00};

  always_comb begin
    data = '0;
    err  = 1'b0;
    unique case (1'b1)
      (sel == SEL_B):     data = b_in;
      (sel == SEL_CONST): data = DATA_W'(CONST_VAL);
      (sel == SEL_SEXT):  data = sext;
      (sel == SEL_SEXT4): data = sext4;
      (sel == SEL_ZEXT):  data = zext;
      (sel == SEL_LUI):   data = lui;
      default: begin
        data = '0;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_srcb_stage.sv
// Registered operand-B stage with a head/skid buffer so the
// control FSM can stall the ALU without dropping an operand.
module alu_srcb_stage
  import alu_srcb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int IMM_W     = 16,
  parameter int CONST_VAL = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  alu_srcb_if.slave  bus
);

  state_t state_q;
  state_t state_d;

  logic [DATA_W:0]   head_q;
  logic [DATA_W:0]   skid_q;
  logic [DATA_W:0]   new_ent;
  logic [DATA_W-1:0] new_data;
  logic              new_err;

  logic in_ready;
  logic out_valid;
  logic in_xfer;
  logic out_xfer;
  logic head_ld;
  logic head_from_skid;
  logic skid_ld;

  alu_srcb_sel #(
    .DATA_W    (DATA_W),
    .IMM_W     (IMM_W),
    .CONST_VAL (CONST_VAL)
  ) u_sel (
    .sel    (bus.sel),
    .b_in   (bus.b_in),
    .imm_in (bus.imm_in),
    .data   (new_data),
    .err    (new_err)
  );

  assign new_ent = {new_err, new_data};

  // Gated by reset so nothing is accepted in the reset cycle.
  assign in_ready  = reset & ~flush & (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = bus.in_valid & in_ready;
  assign out_xfer  = out_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    head_ld        = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          head_ld = 1'b1;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          head_ld = 1'b1;
        end else if (in_xfer) begin
          skid_ld = 1'b1;
          state_d = ST_TWO;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          head_ld        = 1'b1;
          head_from_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      head_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (head_ld) begin
        head_q <= head_from_skid ? skid_q : new_ent;
      end
      if (skid_ld) begin
        skid_q <= new_ent;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head_q[DATA_W-1:0];
  assign bus.out_err   = head_q[DATA_W];

endmodule

// File: tb/tb_alu_srcb_stage.sv
// Bench for alu_srcb_stage: vector table, corner sequences,
// random traffic, all outputs tracked by a scoreboard queue.
module tb_alu_srcb_stage;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] b;
    logic [15:0] imm;
    logic [31:0] d;
    logic        e;
  } vec_t;

  logic clk;
  logic reset;
  logic flush;

  int n_chk;
  int n_fail;

  exp_t sb[$];

  alu_srcb_if #(.DATA_W(32), .IMM_W(16)) bus ();

  alu_srcb_stage #(
    .DATA_W    (32),
    .IMM_W     (16),
    .CONST_VAL (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t ref_op(logic [2:0] s, logic [31:0] b,
                                  logic [15:0] imm);
    exp_t r;
    logic signed [31:0] se;
    se  = $signed(imm);
    r.e = 1'b0;
    case (s)
      3'd0:    r.d = b;
      3'd1:    r.d = 32'd4;
      3'd2:    r.d = se;
      3'd3:    r.d = se * 4;
      3'd4:    r.d = {16'h0000, imm};
      3'd5:    r.d = 32'(imm) * 32'h0001_0000;
      default: begin
        r.d = 32'h0;
        r.e = 1'b1;
      end
    endcase
    return r;
  endfunction

  // One cycle: check combinational outputs, score transfers, advance.
  task automatic tick();
    exp_t e;
    #1;
    chk("in_ready", 64'(bus.in_ready),
        64'(reset && !flush && sb.size() < 2));
    if (reset) begin
      chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: got %0h expected none",
                   bus.out_data);
        end else begin
          e = sb.pop_front();
          chk("sb_data", 64'(bus.out_data), 64'(e.d));
          chk("sb_err", 64'(bus.out_err), 64'(e.e));
        end
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      sb.push_back(ref_op(bus.sel, bus.b_in, bus.imm_in));
    end
    if (!reset || flush) sb.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(logic [2:0] s, logic [31:0] b, logic [15:0] imm);
    bus.in_valid = 1'b1;
    bus.sel      = s;
    bus.b_in     = b;
    bus.imm_in   = imm;
  endtask

  vec_t vt[12];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vt[0]  = '{3'b011, 32'h0,         16'hFFFE, 32'hFFFF_FFF8, 1'b0};
    vt[1]  = '{3'b101, 32'h0,         16'h1234, 32'h1234_0000, 1'b0};
    vt[2]  = '{3'b100, 32'h0,         16'h8000, 32'h0000_8000, 1'b0};
    vt[3]  = '{3'b010, 32'h0,         16'h8000, 32'hFFFF_8000, 1'b0};
    vt[4]  = '{3'b010, 32'h0,         16'h7FFF, 32'h0000_7FFF, 1'b0};
    vt[5]  = '{3'b000, 32'hA5A5_5A5A, 16'h1111, 32'hA5A5_5A5A, 1'b0};
    vt[6]  = '{3'b110, 32'hFFFF_FFFF, 16'hFFFF, 32'h0,         1'b1};
    vt[7]  = '{3'b001, 32'h0,         16'h0,    32'h0000_0004, 1'b0};
    vt[8]  = '{3'b111, 32'hFFFF_FFFF, 16'hABCD, 32'h0,         1'b1};
    vt[9]  = '{3'b011, 32'h0,         16'h4000, 32'h0001_0000, 1'b0};
    vt[10] = '{3'b101, 32'h0,         16'hFFFF, 32'hFFFF_0000, 1'b0};
    vt[11] = '{3'b011, 32'h0,         16'h7FFF, 32'h0001_FFFC, 1'b0};

    reset         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sel       = 3'b000;
    bus.b_in      = '0;
    bus.imm_in    = '0;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Vector table, one request at a time with the consumer ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].sel, vt[i].b, vt[i].imm);
      tick();
      bus.in_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("vec%0d_data", i), 64'(bus.out_data), 64'(vt[i].d));
      chk($sformatf("vec%0d_err", i), 64'(bus.out_err), 64'(vt[i].e));
      tick();
    end

    // Stall: fill both entries, then drain in order.
    bus.out_ready = 1'b0;
    drive(3'b000, 32'd5, 16'h0);
    tick();
    drive(3'b000, 32'd7, 16'h0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("two_in_ready", 64'(bus.in_ready), 64'd0);
    chk("two_head", 64'(bus.out_data), 64'd5);
    tick();
    #1;
    chk("two_hold", 64'(bus.out_data), 64'd5);
    bus.out_ready = 1'b1;
    tick();
    #1;
    chk("two_second", 64'(bus.out_data), 64'd7);
    tick();
    #1;
    chk("two_drained", 64'(bus.out_valid), 64'd0);

    // Flush from TWO with a competing request.
    bus.out_ready = 1'b0;
    drive(3'b000, 32'd11, 16'h0);
    tick();
    drive(3'b000, 32'd12, 16'h0);
    tick();
    drive(3'b000, 32'd13, 16'h0);
    flush = 1'b1;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    tick();

    // Reset while holding one entry.
    bus.out_ready = 1'b0;
    drive(3'b001, 32'h0, 16'h0);
    tick();
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_data", 64'(bus.out_data), 64'd0);
    drive(3'b000, 32'hDEAD_BEEF, 16'h0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("post_rst_data", 64'(bus.out_data), 64'hDEAD_BEEF);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    tick();

    // Random traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.sel       = 3'($urandom_range(0, 7));
      bus.b_in      = $urandom;
      bus.imm_in    = 16'($urandom);
      flush         = ($urandom_range(0, 24) == 0);
      tick();
    end
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("final_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
